alu_suma_resta: RTL and testbench

ALU_SUMA_RESTA -- requirements
Module: alu_suma_resta

---
 rtl/alu_pkg.sv | 26 ++
 rtl/nucleo_suma_resta.sv | 28 ++
 rtl/alu_suma_resta.sv | 114 +++++++++++
 tb/tb_alu_suma_resta.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the add/subtract ALU: operation modes and status flags.
package alu_pkg;

  typedef enum logic [1:0] {
    MODO_SUMA       = 2'b00,
    MODO_RESTA      = 2'b01,
    MODO_ACUM_SUMA  = 2'b10,
    MODO_ACUM_RESTA = 2'b11
  } modo_t;

  typedef struct packed {
    logic cero;
    logic negativo;
    logic acarreo;
    logic desborde;
  } flags_t;

  function automatic logic es_acumulacion(input modo_t m);
    return (m == MODO_ACUM_SUMA) || (m == MODO_ACUM_RESTA);
  endfunction

  function automatic logic es_resta(input modo_t m);
    return (m == MODO_RESTA) || (m == MODO_ACUM_RESTA);
  endfunction

endpackage

// File: rtl/nucleo_suma_resta.sv
// Combinational add/subtract core with optional signed saturation.
module nucleo_suma_resta #(
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned SATURAR = 0
) (
  input  logic [N_BITS-1:0] x,
  input  logic [N_BITS-1:0] y,
  input  logic              resta,
  output logic [N_BITS-1:0] resultado,
  output logic              acarreo,
  output logic              desborde
);

  logic [N_BITS-1:0] y_op;
  logic [N_BITS:0]   suma_raw;
  logic [N_BITS-1:0] valor_sat;

  always_comb begin
    y_op      = resta ? ~y : y;
    suma_raw  = {1'b0, x} + {1'b0, y_op} + {{N_BITS{1'b0}}, resta};
    acarreo   = suma_raw[N_BITS];
    // Comparing against the inverted operand covers both the add and subtract overflow rules.
    desborde  = (x[N_BITS-1] == y_op[N_BITS-1]) && (suma_raw[N_BITS-1] != x[N_BITS-1]);
    valor_sat = x[N_BITS-1] ? {1'b1, {(N_BITS-1){1'b0}}} : {1'b0, {(N_BITS-1){1'b1}}};
    resultado = ((SATURAR != 0) && desborde) ? valor_sat : suma_raw[N_BITS-1:0];
  end

endmodule

// File: rtl/alu_suma_resta.sv
// Two-stage pipelined add/subtract ALU with accumulator and status flags.
module alu_suma_resta
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned SATURAR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valido_entrada,
  input  logic [N_BITS-1:0] entrada_a,
  input  logic [N_BITS-1:0] entrada_b,
  input  logic [1:0]        modo,
  input  logic              limpiar_acc,
  output logic [N_BITS-1:0] resultado,
  output logic              valido_salida,
  output logic              cero,
  output logic              negativo,
  output logic              acarreo,
  output logic              desborde
);

  modo_t             modo_e;
  logic              acum;
  logic              op_resta;
  logic [N_BITS-1:0] acc;
  logic [N_BITS-1:0] acc_op;
  logic [N_BITS-1:0] op_x;
  logic [N_BITS-1:0] op_y;

  logic [N_BITS-1:0] res_n;
  logic              acarreo_n;
  logic              desborde_n;
  flags_t            flags_n;

  logic              s1_valido;
  logic [N_BITS-1:0] s1_res;
  flags_t            s1_flags;
  flags_t            flags_q;

  // Clearing alongside an accumulate feeds zero into this same operation.
  always_comb begin
    modo_e   = modo_t'(modo);
    acum     = es_acumulacion(modo_e);
    op_resta = es_resta(modo_e);
    acc_op   = limpiar_acc ? '0 : acc;
    op_x     = acum ? acc_op : entrada_a;
    op_y     = acum ? entrada_a : entrada_b;
  end

  nucleo_suma_resta #(
    .N_BITS  (N_BITS),
    .SATURAR (SATURAR)
  ) u_nucleo (
    .x         (op_x),
    .y         (op_y),
    .resta     (op_resta),
    .resultado (res_n),
    .acarreo   (acarreo_n),
    .desborde  (desborde_n)
  );

  always_comb begin
    flags_n          = '0;
    flags_n.cero     = (res_n == '0);
    flags_n.negativo = res_n[N_BITS-1];
    flags_n.acarreo  = acarreo_n;
    flags_n.desborde = desborde_n;
  end

  // Stage 1: capture the computed result and update the accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valido <= 1'b0;
      s1_res    <= '0;
      s1_flags  <= '0;
      acc       <= '0;
    end else begin
      s1_valido <= valido_entrada;
      if (valido_entrada) begin
        s1_res   <= res_n;
        s1_flags <= flags_n;
      end
      if (valido_entrada && acum) begin
        acc <= res_n;
      end else if (limpiar_acc) begin
        acc <= '0;
      end
    end
  end

  // Stage 2: output registers hold their value across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valido_salida <= 1'b0;
      resultado     <= '0;
      flags_q       <= '0;
    end else begin
      valido_salida <= s1_valido;
      if (s1_valido) begin
        resultado <= s1_res;
        flags_q   <= s1_flags;
      end
    end
  end

  always_comb begin
    cero     = flags_q.cero;
    negativo = flags_q.negativo;
    acarreo  = flags_q.acarreo;
    desborde = flags_q.desborde;
  end

endmodule

// File: tb/tb_alu_suma_resta.sv
// Scoreboard bench: wrap-around and saturating instances driven in parallel.
module tb_alu_suma_resta;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valido_entrada = 1'b0;
  logic [7:0] entrada_a = '0;
  logic [7:0] entrada_b = '0;
  logic [1:0] modo = '0;
  logic       limpiar_acc = 1'b0;

  logic [7:0] res_w, res_s;
  logic       vs_w, vs_s;
  logic       z_w, n_w, c_w, d_w;
  logic       z_s, n_s, c_s, d_s;

  typedef struct {
    logic [7:0] r0;
    logic [3:0] f0;
    logic [7:0] r1;
    logic [3:0] f1;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         have_last = 0;
  logic [7:0] last_w, last_s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_suma_resta #(.N_BITS(8), .SATURAR(0)) u_wrap (
    .clk(clk), .reset(reset), .valido_entrada(valido_entrada),
    .entrada_a(entrada_a), .entrada_b(entrada_b), .modo(modo),
    .limpiar_acc(limpiar_acc), .resultado(res_w), .valido_salida(vs_w),
    .cero(z_w), .negativo(n_w), .acarreo(c_w), .desborde(d_w)
  );

  alu_suma_resta #(.N_BITS(8), .SATURAR(1)) u_sat (
    .clk(clk), .reset(reset), .valido_entrada(valido_entrada),
    .entrada_a(entrada_a), .entrada_b(entrada_b), .modo(modo),
    .limpiar_acc(limpiar_acc), .resultado(res_s), .valido_salida(vs_s),
    .cero(z_s), .negativo(n_s), .acarreo(c_s), .desborde(d_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Flags in order {cero, negativo, acarreo, desborde}.
  task automatic issue(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                       input logic clr, input logic [7:0] r0, input logic [3:0] f0,
                       input logic [7:0] r1, input logic [3:0] f1);
    exp_t e;
    @(posedge clk);
    #1;
    valido_entrada = 1'b1;
    modo = m;
    entrada_a = a;
    entrada_b = b;
    limpiar_acc = clr;
    e.r0 = r0; e.f0 = f0; e.r1 = r1; e.f1 = f1; e.cyc = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      valido_entrada = 1'b0;
      limpiar_acc = 1'b0;
    end
  endtask

  // Monitor: pops on every valid output, checks hold value during bubbles.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      have_last = 0;
    end else if (vs_w || vs_s) begin
      check("valid_match", {31'b0, vs_s}, {31'b0, vs_w});
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("latency", cyc, e.cyc);
        check("res_wrap", {24'b0, res_w}, {24'b0, e.r0});
        check("flags_wrap", {28'b0, z_w, n_w, c_w, d_w}, {28'b0, e.f0});
        check("res_sat", {24'b0, res_s}, {24'b0, e.r1});
        check("flags_sat", {28'b0, z_s, n_s, c_s, d_s}, {28'b0, e.f1});
        last_w = e.r0;
        last_s = e.r1;
        have_last = 1;
      end
    end else if (have_last) begin
      check("hold_wrap", {24'b0, res_w}, {24'b0, last_w});
      check("hold_sat", {24'b0, res_s}, {24'b0, last_s});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_res", {24'b0, res_w}, 32'd0);
    check("rst_valid", {31'b0, vs_w}, 32'd0);
    check("rst_flags", {28'b0, z_w, n_w, c_w, d_w}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    issue(2'b01, 8'd5,   8'd3,   1'b0, 8'h02, 4'b0010, 8'h02, 4'b0010);
    idle(2);
    issue(2'b01, 8'd3,   8'd5,   1'b0, 8'hFE, 4'b0100, 8'hFE, 4'b0100);
    issue(2'b01, 8'h80,  8'h80,  1'b0, 8'h00, 4'b1010, 8'h00, 4'b1010);
    issue(2'b00, 8'h7F,  8'h01,  1'b0, 8'h80, 4'b0101, 8'h7F, 4'b0001);
    issue(2'b00, 8'h80,  8'hFF,  1'b0, 8'h7F, 4'b0011, 8'h80, 4'b0111);
    issue(2'b01, 8'h80,  8'h01,  1'b0, 8'h7F, 4'b0011, 8'h80, 4'b0111);
    idle(1);

    @(posedge clk);
    #1;
    valido_entrada = 1'b0;
    limpiar_acc = 1'b1;
    issue(2'b10, 8'd10,  8'h00,  1'b0, 8'd10, 4'b0000, 8'd10, 4'b0000);
    issue(2'b10, 8'd20,  8'h00,  1'b0, 8'd30, 4'b0000, 8'd30, 4'b0000);
    issue(2'b10, 8'd30,  8'h00,  1'b0, 8'd60, 4'b0000, 8'd60, 4'b0000);
    issue(2'b11, 8'd70,  8'h00,  1'b0, 8'hF6, 4'b0100, 8'hF6, 4'b0100);
    issue(2'b00, 8'd1,   8'd2,   1'b0, 8'd3,  4'b0000, 8'd3,  4'b0000);
    issue(2'b10, 8'd5,   8'h00,  1'b1, 8'd5,  4'b0000, 8'd5,  4'b0000);
    idle(4);

    issue(2'b10, 8'h33,  8'h00,  1'b0, 8'h38, 4'b0000, 8'h38, 4'b0000);
    @(posedge clk);
    #2;
    valido_entrada = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_res", {24'b0, res_w}, 32'd0);
    check("midrst_valid", {31'b0, vs_w}, 32'd0);
    check("midrst_res_sat", {24'b0, res_s}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    issue(2'b10, 8'd5,   8'h00,  1'b0, 8'd5,  4'b0000, 8'd5,  4'b0000);
    idle(5);

    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
